// File: rtl/traffic_ctrl_nway.sv
// N-approach sensor-actuated signal controller: round-robin service of latched
// demand, green extension on the serving approach's sensor, capped green.
module traffic_ctrl_nway #(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 10,
    parameter int unsigned GREEN_MAX = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    localparam int unsigned IDX_W    = (NUM_WAYS > 2) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WAYS-1:0]     SENSOR,
    output logic [3*NUM_WAYS-1:0]   lights,
    output logic [IDX_W-1:0]        active_way,
    output logic [1:0]              phase,
    output logic [CNT_W-1:0]        count
);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        ALLRED = 2'b10
    } phase_t;

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [3*NUM_WAYS-1:0] RST_LIGHTS = {{(NUM_WAYS-1){3'b100}}, 3'b001};

    phase_t                  state, state_nxt;
    logic [IDX_W-1:0]        way_nxt;
    logic [IDX_W-1:0]        next_way, next_way_nxt;
    logic [IDX_W-1:0]        sel_way;
    logic                    sel_valid;
    logic [CNT_W-1:0]        count_nxt;
    logic [NUM_WAYS-1:0]     req, req_nxt;
    logic [3*NUM_WAYS-1:0]   lights_nxt;

    assign phase = state;

    // Round-robin search of latched demand after the active approach; main road is the fallback
    always_comb begin
        int unsigned k;
        k         = 0;
        sel_valid = 1'b0;
        sel_way   = '0;
        for (int unsigned i = 1; i < NUM_WAYS; i++) begin
            k = (32'(active_way) + i) % NUM_WAYS;
            if (!sel_valid && k != 0 && req[IDX_W'(k)]) begin
                sel_valid = 1'b1;
                sel_way   = IDX_W'(k);
            end
        end
        if (!sel_valid && active_way != '0) begin
            sel_valid = 1'b1;
            sel_way   = '0;
        end
    end

    // Phase sequencing, demand latching and light decode
    always_comb begin
        state_nxt    = state;
        way_nxt      = active_way;
        next_way_nxt = next_way;
        count_nxt    = count;
        req_nxt      = req;
        lights_nxt   = RST_LIGHTS;

        case (state)
            GREEN: begin
                if (count >= MIN_LAST && sel_valid &&
                    (!SENSOR[active_way] || count == MAX_LAST)) begin
                    state_nxt    = YELLOW;
                    next_way_nxt = sel_way;
                    count_nxt    = '0;
                end else if (count != MAX_LAST) begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            YELLOW: begin
                if (count == Y_LAST) begin
                    state_nxt = ALLRED;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            ALLRED: begin
                if (count == AR_LAST) begin
                    state_nxt = GREEN;
                    way_nxt   = next_way;
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = GREEN;
                way_nxt   = '0;
                count_nxt = '0;
            end
        endcase

        // Own demand is never latched while green, including the first green cycle
        for (int unsigned k = 0; k < NUM_WAYS; k++) begin
            req_nxt[k] = req[k] | SENSOR[k];
            if ((state == GREEN && active_way == IDX_W'(k)) ||
                (state_nxt == GREEN && way_nxt == IDX_W'(k))) begin
                req_nxt[k] = 1'b0;
            end
            if (way_nxt == IDX_W'(k) && state_nxt == GREEN) begin
                lights_nxt[3*k +: 3] = 3'b001;
            end else if (way_nxt == IDX_W'(k) && state_nxt == YELLOW) begin
                lights_nxt[3*k +: 3] = 3'b010;
            end else begin
                lights_nxt[3*k +: 3] = 3'b100;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GREEN;
            active_way <= '0;
            next_way   <= '0;
            count      <= '0;
            req        <= '0;
            lights     <= RST_LIGHTS;
        end else begin
            state      <= state_nxt;
            active_way <= way_nxt;
            next_way   <= next_way_nxt;
            count      <= count_nxt;
            req        <= req_nxt;
            lights     <= lights_nxt;
        end
    end

endmodule
